alu_ctl_seq: RTL and testbench

Parametrised successor to the combinational ALU control decoder. It decodes ALUop/func into the ALU control code and add/sub flags, and adds an iterative multi-cycle multiply/divide sequencer with HI/LO result registers. A busy/stall handshake holds the pipeline while a mult/div runs, or while mfhi/mflo would read a result that is not yet ready. The block sits between the ID stage (func, ALUop, operands) and the EX stage.

---
 rtl/alu_ctl_pkg.sv | 61 ++++++
 rtl/alu_muldiv_core.sv | 113 +++++++++++
 rtl/alu_ctl_seq.sv | 104 ++++++++++
 tb/tb_alu_ctl_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_pkg.sv
// Shared constants for the ALU control decoder and the mult/div sequencer:
// function codes, ALUCtl codes, FSM state and mult/div operation encodings.
package alu_ctl_pkg;

    localparam logic [5:0] FUNC_MFHI  = 6'd16;
    localparam logic [5:0] FUNC_MFLO  = 6'd18;
    localparam logic [5:0] FUNC_MULT  = 6'd24;
    localparam logic [5:0] FUNC_MULTU = 6'd25;
    localparam logic [5:0] FUNC_DIV   = 6'd26;
    localparam logic [5:0] FUNC_DIVU  = 6'd27;
    localparam logic [5:0] FUNC_ADD   = 6'd32;
    localparam logic [5:0] FUNC_SUB   = 6'd34;
    localparam logic [5:0] FUNC_AND   = 6'd36;
    localparam logic [5:0] FUNC_OR    = 6'd37;
    localparam logic [5:0] FUNC_XOR   = 6'd38;
    localparam logic [5:0] FUNC_NOR   = 6'd39;
    localparam logic [5:0] FUNC_SLT   = 6'd42;
    localparam logic [5:0] FUNC_SLTU  = 6'd43;

    localparam logic [3:0] CTL_AND  = 4'd0;
    localparam logic [3:0] CTL_OR   = 4'd1;
    localparam logic [3:0] CTL_ADD  = 4'd2;
    localparam logic [3:0] CTL_XOR  = 4'd3;
    localparam logic [3:0] CTL_SUB  = 4'd6;
    localparam logic [3:0] CTL_SLT  = 4'd7;
    localparam logic [3:0] CTL_SLTU = 4'd8;
    localparam logic [3:0] CTL_NOR  = 4'd12;
    localparam logic [3:0] CTL_NONE = 4'd15;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} seq_state_e;

    // Encoding matches func[1:0] of the mult/div function codes.
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} muldiv_op_e;

    function automatic logic [3:0] decode_alu_ctl(input logic [1:0] alu_op, input logic [5:0] fn);
        logic [3:0] ctl;
        ctl = CTL_NONE;
        case (alu_op)
            2'd0: ctl = CTL_ADD;
            2'd1: ctl = CTL_SUB;
            2'd2: begin
                case (fn)
                    FUNC_ADD:  ctl = CTL_ADD;
                    FUNC_SUB:  ctl = CTL_SUB;
                    FUNC_AND:  ctl = CTL_AND;
                    FUNC_OR:   ctl = CTL_OR;
                    FUNC_XOR:  ctl = CTL_XOR;
                    FUNC_NOR:  ctl = CTL_NOR;
                    FUNC_SLT:  ctl = CTL_SLT;
                    FUNC_SLTU: ctl = CTL_SLTU;
                    FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
                    FUNC_MFHI, FUNC_MFLO: ctl = CTL_NONE;
                    default:   ctl = CTL_NONE;
                endcase
            end
            default: ctl = CTL_NONE;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative one-bit-per-cycle shift-add multiplier and restoring divider with HI/LO.
// The divider datapath exists only when ALU_CTL_DIV_EN is defined.
module alu_muldiv_core
    import alu_ctl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  muldiv_op_e       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);

    logic                 r_run;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;      // {accumulator/remainder, multiplier/quotient}
    logic [WIDTH-1:0]     r_m;      // multiplicand or divisor magnitude
    logic                 r_neg_q;

    logic                 w_signed;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next, w_prod, w_step;
    logic [WIDTH-1:0]     w_res_hi, w_res_lo;

    // o_done marks the final iteration; HI/LO load on the edge that ends it.
    assign o_done = r_run && (r_cnt == CW'(WIDTH - 1));

`ifdef ALU_CTL_DIV_EN
    logic                 r_div;
    logic                 r_neg_r;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_trial, w_quot, w_rem;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_signed    = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_is_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
    assign w_rem_sh    = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_m});
    assign w_rem_trial = w_rem_sh[WIDTH-1:0] - r_m;
    assign w_div_next  = {(w_ge ? w_rem_trial : w_rem_sh[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};
    assign w_quot      = w_div_next[WIDTH-1:0];
    assign w_rem       = w_div_next[2*WIDTH-1:WIDTH];
    assign w_step      = r_div ? w_div_next : w_mul_next;
`else
    assign w_signed    = (i_op == OP_MULT);
    assign w_is_div    = 1'b0;
    assign w_step      = w_mul_next;
`endif

    assign w_mag_a    = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b    = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_sum      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_sum, r_p[WIDTH-1:1]};
    assign w_prod     = r_neg_q ? -w_mul_next : w_mul_next;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
`ifdef ALU_CTL_DIV_EN
        if (r_div) begin
            w_res_hi = r_neg_r ? -w_rem : w_rem;
            w_res_lo = r_neg_q ? -w_quot : w_quot;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            o_hi    <= '0;
            o_lo    <= '0;
`ifdef ALU_CTL_DIV_EN
            r_div   <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (i_start) begin
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_p     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_m     <= w_is_div ? w_mag_b : w_mag_a;
            // A zero divisor keeps the all-ones quotient un-negated; a zero product is unaffected.
            r_neg_q <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]) && (|i_b);
`ifdef ALU_CTL_DIV_EN
            r_div   <= w_is_div;
            r_neg_r <= w_signed && i_a[WIDTH-1];
`endif
        end else if (r_run) begin
            r_p   <= w_step;
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_run <= 1'b0;
                r_cnt <= '0;
                o_hi  <= w_res_hi;
                o_lo  <= w_res_lo;
            end
        end
    end

endmodule

// File: rtl/alu_ctl_seq.sv
// ALU control decoder with a busy/stall-handshaked multi-cycle mult/div sequencer.
// Define ALU_CTL_DIV_EN to include div/divu; otherwise only multiply is supported.
module alu_ctl_seq
    import alu_ctl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [CTL_W-1:0] ALUCtl,
    output logic             add,
    output logic             sub,
    output logic             hi_sel,
    output logic             lo_sel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);
    seq_state_e r_state;
    logic       r_busy;
    logic       r_done;

    logic       w_rtype;
    logic       w_is_div;
    logic       w_is_muldiv;
    logic       w_accept;
    logic       w_core_done;

    assign w_rtype = (ALUop == 2'd2);
    assign ALUCtl  = CTL_W'(decode_alu_ctl(ALUop, func));
    assign add     = w_rtype && (func == FUNC_ADD);
    assign sub     = w_rtype && (func == FUNC_SUB);
    assign hi_sel  = w_rtype && (func == FUNC_MFHI);
    assign lo_sel  = w_rtype && (func == FUNC_MFLO);

`ifdef ALU_CTL_DIV_EN
    assign w_is_div = w_rtype && ((func == FUNC_DIV) || (func == FUNC_DIVU));
`else
    assign w_is_div = 1'b0;
`endif
    assign w_is_muldiv = (w_rtype && ((func == FUNC_MULT) || (func == FUNC_MULTU))) || w_is_div;

    // A mult/div only starts from IDLE; otherwise it is held off by stall and re-presented.
    assign w_accept = valid_i && w_is_muldiv && (r_state == ST_IDLE);
    assign stall    = valid_i && r_busy && (w_is_muldiv || hi_sel || lo_sel);
    assign busy     = r_busy;
    assign done     = r_done;

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept),
        .i_op    (muldiv_op_e'(func[1:0])),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_core_done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= w_is_div ? ST_DIV : ST_MUL;
                        r_busy  <= 1'b1;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_core_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Self-checking bench for alu_ctl_seq: decode table, mult/div scoreboard, stall and reset abort.
// div/divu results are checked when ALU_CTL_DIV_EN is defined, rejection of div otherwise.
module tb_alu_ctl_seq;
    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] ctl;
        logic [3:0] flg;   // {add, sub, hi_sel, lo_sel}
    } dec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic [1:0]   ALUop;
    logic [5:0]   func;
    logic [W-1:0] a, b;
    logic [3:0]   ALUCtl;
    logic         add, sub, hi_sel, lo_sel;
    logic [W-1:0] hi, lo;
    logic         busy, stall, done;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t sb_q[$];
    res_t mon_exp;
    res_t last_exp = '0;

    alu_ctl_seq #(.WIDTH(W), .CTL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUop(ALUop), .func(func),
        .a(a), .b(b), .ALUCtl(ALUCtl), .add(add), .sub(sub), .hi_sel(hi_sel),
        .lo_sel(lo_sel), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard: each done pulse pops one expected {hi, lo}.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: done=1 with no operation outstanding");
            end else begin
                mon_exp = sb_q.pop_front();
                last_exp = mon_exp;
                if (hi !== mon_exp.hi || lo !== mon_exp.lo) begin
                    n_fail++;
                    $display("FAIL result: hi=%h lo=%h expected hi=%h lo=%h", hi, lo, mon_exp.hi, mon_exp.lo);
                end
            end
        end
    end

    function automatic logic [2*W-1:0] mul_model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        longint sx, sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

`ifdef ALU_CTL_DIV_EN
    function automatic logic [2*W-1:0] div_model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        longint sq, sr;
        logic [W-1:0] uq, ur;
        if (y == 0) return {x, {W{1'b1}}};
        if (sgn) begin
            sq = longint'($signed(x)) / longint'($signed(y));
            sr = longint'($signed(x)) % longint'($signed(y));
            return {sr[W-1:0], sq[W-1:0]};
        end
        uq = x / y;
        ur = x % y;
        return {ur, uq};
    endfunction
`endif

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] av, input logic [W-1:0] bv);
        valid_i = v; ALUop = op; func = fn; a = av; b = bv;
    endtask

    // Present a mult/div for one accepting edge and record its expected result.
    task automatic issue(input logic [5:0] fn, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] exp);
        @(negedge clk);
        drive(1'b1, 2'd2, fn, av, bv);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_idle: busy=%b required 0 before func %0d", busy, fn);
        end
        sb_q.push_back(res_t'(exp));
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 6'd0, '0, '0);
    endtask

    // Returns the negedge index (0 = first after the accept edge) where done appeared.
    task automatic wait_done(input string tag, output int cyc, output bit busy_ok);
        cyc = -1;
        busy_ok = 1'b1;
        for (int k = 0; k <= W + 8; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", tag, W + 8);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'd1, 6'd0, '0, '0);
        #3;
        n_tests += 5;
        if (hi !== '0)     begin n_fail++; $display("FAIL reset_hi: got %h required 0", hi); end
        if (lo !== '0)     begin n_fail++; $display("FAIL reset_lo: got %h required 0", lo); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        if (ALUCtl !== 4'd6) begin n_fail++; $display("FAIL reset_decode: ALUCtl=%0d required 6", ALUCtl); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 6'd0, '0, '0);
    endtask

    task automatic test_decode();
        dec_t tbl[16] = '{
            '{2'd0, 6'd32, 4'd2,  4'b0000},
            '{2'd1, 6'd0,  4'd6,  4'b0000},
            '{2'd3, 6'd0,  4'd15, 4'b0000},
            '{2'd2, 6'd32, 4'd2,  4'b1000},
            '{2'd2, 6'd34, 4'd6,  4'b0100},
            '{2'd2, 6'd36, 4'd0,  4'b0000},
            '{2'd2, 6'd37, 4'd1,  4'b0000},
            '{2'd2, 6'd38, 4'd3,  4'b0000},
            '{2'd2, 6'd39, 4'd12, 4'b0000},
            '{2'd2, 6'd42, 4'd7,  4'b0000},
            '{2'd2, 6'd43, 4'd8,  4'b0000},
            '{2'd2, 6'd63, 4'd15, 4'b0000},
            '{2'd2, 6'd16, 4'd15, 4'b0010},
            '{2'd2, 6'd18, 4'd15, 4'b0001},
            '{2'd2, 6'd24, 4'd15, 4'b0000},
            '{2'd2, 6'd27, 4'd15, 4'b0000}
        };
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, tbl[i].op, tbl[i].fn, '0, '0);
            #1;
            n_tests += 2;
            if (ALUCtl !== tbl[i].ctl) begin
                n_fail++;
                $display("FAIL decode_ctl[%0d]: ALUop=%0d func=%0d got %0d required %0d",
                         i, tbl[i].op, tbl[i].fn, ALUCtl, tbl[i].ctl);
            end
            if ({add, sub, hi_sel, lo_sel} !== tbl[i].flg) begin
                n_fail++;
                $display("FAIL decode_flags[%0d]: ALUop=%0d func=%0d got %b required %b",
                         i, tbl[i].op, tbl[i].fn, {add, sub, hi_sel, lo_sel}, tbl[i].flg);
            end
        end
        drive(1'b0, 2'd0, 6'd0, '0, '0);
    endtask

    task automatic test_mult();
        int cyc;
        bit bok;
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
        wait_done("multu_max", cyc, bok);
        issue(F_MULT, 32'h8000_0000, 32'd2, mul_model(32'h8000_0000, 32'd2, 1'b1));
        wait_done("mult_minneg", cyc, bok);
        issue(F_MULT, -32'sd5, -32'sd9, mul_model(-32'sd5, -32'sd9, 1'b1));
        wait_done("mult_negneg", cyc, bok);
        issue(F_MULT, 32'd7, 32'hFFFF_FFFD, mul_model(32'd7, 32'hFFFF_FFFD, 1'b1));
        wait_done("mult_7_m3", cyc, bok);
        n_tests += 2;
        if (cyc !== W) begin n_fail++; $display("FAIL mult_latency: done at cycle %0d required %0d", cyc, W); end
        if (!bok)      begin n_fail++; $display("FAIL mult_busy: busy dropped during operation, required 1"); end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int dcnt = 0;
        issue(F_MULT, 32'd5, 32'd6, mul_model(32'd5, 32'd6, 1'b1));
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests += 4;
        if (hi !== '0)     begin n_fail++; $display("FAIL abort_hi: got %h required 0", hi); end
        if (lo !== '0)     begin n_fail++; $display("FAIL abort_lo: got %h required 0", lo); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b required 0", done); end
        sb_q.delete();
        last_exp = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        n_tests += 2;
        if (dcnt !== 0)    begin n_fail++; $display("FAIL abort_no_done: %0d done pulses, required 0", dcnt); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back_stall();
        int j = -1;
        int cyc;
        bit bok;
        logic [2*W-1:0] e1 = mul_model(32'h1234_5678, 32'h10, 1'b0);
        issue(F_MULTU, 32'h1234_5678, 32'h10, e1);
        @(negedge clk); drive(1'b1, 2'd2, F_MFLO, '0, '0); #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_mflo: stall=%b required 1", stall); end
        @(negedge clk); drive(1'b1, 2'd2, F_MFHI, '0, '0); #1;
        n_tests++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_mfhi: stall=%b required 1", stall); end
        @(negedge clk); drive(1'b1, 2'd2, F_ADD, 32'd1, 32'd2); #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_alu: stall=%b required 0", stall); end
        // Hold a second mult until stall drops; it must be accepted only once IDLE.
        @(negedge clk); drive(1'b1, 2'd2, F_MULT, 32'd3, 32'd5);
        for (int k = 3; k < W + 12; k++) begin
            #1;
            if (stall === 1'b0) begin
                j = k;
                break;
            end
            @(negedge clk);
        end
        n_tests += 4;
        if (j !== W + 1) begin n_fail++; $display("FAIL stall_release: stall dropped at cycle %0d required %0d", j, W + 1); end
        if (sb_q.size() !== 0) begin n_fail++; $display("FAIL stall_first_done: %0d results outstanding, required 0", sb_q.size()); end
        if (lo !== e1[W-1:0]) begin n_fail++; $display("FAIL mflo_new: lo=%h required %h", lo, e1[W-1:0]); end
        if (hi !== e1[2*W-1:W]) begin n_fail++; $display("FAIL mfhi_new: hi=%h required %h", hi, e1[2*W-1:W]); end
        sb_q.push_back(res_t'(mul_model(32'd3, 32'd5, 1'b1)));
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 6'd0, '0, '0);
        wait_done("mult_second", cyc, bok);
        n_tests++;
        if (cyc !== W) begin n_fail++; $display("FAIL second_latency: done at cycle %0d required %0d", cyc, W); end
        @(negedge clk);
    endtask

`ifdef ALU_CTL_DIV_EN
    task automatic test_div();
        int cyc;
        bit bok;
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2, div_model(32'hFFFF_FFF9, 32'd2, 1'b1));
        wait_done("div_m7_2", cyc, bok);
        n_tests += 2;
        if (cyc !== W) begin n_fail++; $display("FAIL div_latency: done at cycle %0d required %0d", cyc, W); end
        if (!bok)      begin n_fail++; $display("FAIL div_busy: busy dropped during operation, required 1"); end
        issue(F_DIVU, 32'd5, 32'd0, div_model(32'd5, 32'd0, 1'b0));
        wait_done("divu_by0", cyc, bok);
        issue(F_DIV, 32'hFFFF_FFF9, 32'd0, div_model(32'hFFFF_FFF9, 32'd0, 1'b1));
        wait_done("div_neg_by0", cyc, bok);
        issue(F_DIV, 32'd7, -32'sd2, div_model(32'd7, -32'sd2, 1'b1));
        wait_done("div_7_m2", cyc, bok);
        issue(F_DIVU, 32'hFFFF_FFF0, 32'd7, div_model(32'hFFFF_FFF0, 32'd7, 1'b0));
        wait_done("divu_big", cyc, bok);
        @(negedge clk);
    endtask
`else
    task automatic test_div_disabled();
        int cyc;
        bit bok;
        @(negedge clk);
        drive(1'b1, 2'd2, F_DIV, 32'd9, 32'd3);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL div_off_stall: stall=%b required 0", stall); end
        @(negedge clk);
        n_tests += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL div_off_busy: busy=%b required 0", busy); end
        if (hi !== last_exp.hi) begin n_fail++; $display("FAIL div_off_hi: hi=%h required %h", hi, last_exp.hi); end
        if (lo !== last_exp.lo) begin n_fail++; $display("FAIL div_off_lo: lo=%h required %h", lo, last_exp.lo); end
        drive(1'b0, 2'd0, 6'd0, '0, '0);
        issue(F_MULTU, 32'd2, 32'd3, mul_model(32'd2, 32'd3, 1'b0));
        @(negedge clk);
        drive(1'b1, 2'd2, F_DIVU, 32'd8, 32'd2);
        #1;
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL div_off_busy_stall: stall=%b required 0", stall); end
        @(negedge clk);
        drive(1'b0, 2'd0, 6'd0, '0, '0);
        wait_done("mult_after_div", cyc, bok);
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL div_off_idle: busy=%b required 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_mult();
        test_reset_abort();
        test_back_to_back_stall();
`ifdef ALU_CTL_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
